// File: rtl/four_way_demux_component.sv
// four_way_demux_component: registered 1-to-4 demux with a valid/ready slot per output
// and a wrapping count of accepted input words.
module four_way_demux_component #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [15:0]      xfer_count
);
    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [15:0]      r_count;
    logic             w_in_xfer;
    logic [3:0]       w_drain;

    // Only the selected slot gates the producer, so a stalled consumer blocks nobody else.
    always_comb begin
        in_ready  = !r_valid[op] || out_ready[op];
        w_in_xfer = in_valid && in_ready;
        w_drain   = r_valid & out_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_data[k] <= '0;
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_in_xfer && op == 2'(k)) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (w_drain[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            if (w_in_xfer) r_count <= r_count + 16'd1;
        end
    end

    assign out1       = r_data[0];
    assign out2       = r_data[1];
    assign out3       = r_data[2];
    assign out4       = r_data[3];
    assign out_valid  = r_valid;
    assign xfer_count = r_count;
endmodule

// File: tb/tb_four_way_demux_component.sv
// tb_four_way_demux_component: directed checks of routing, back-pressure, streaming,
// counter wrap and asynchronous reset.
module tb_four_way_demux_component;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] out1, out2, out3, out4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] xfer_count;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_hs = 0;

    four_way_demux_component #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    // Consumer-side handshakes on slot 3, counted independently of the DUT's counter.
    always @(posedge clock) if (!reset && out_valid[2] && out_ready[2]) n_hs <= n_hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out1"}, 32'(out1), 32'h0);
        chk({tag, "_out2"}, 32'(out2), 32'h0);
        chk({tag, "_out3"}, 32'(out3), 32'h0);
        chk({tag, "_out4"}, 32'(out4), 32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_ready"}, 32'(in_ready), 32'h1);
        chk({tag, "_count"}, 32'(xfer_count), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        op = 2'd0;
        out_ready = 4'b0000;
        #12;
        chk_cleared("reset");
        @(negedge clock) reset = 1'b0;

        // Basic routing, no consumer ready
        in_valid = 1'b1;
        in_data = 16'h1111; op = 2'd0;
        @(negedge clock) begin in_data = 16'h2222; op = 2'd1; end
        @(negedge clock) begin in_data = 16'h3333; op = 2'd2; end
        @(negedge clock) begin in_data = 16'h4444; op = 2'd3; end
        @(negedge clock) in_valid = 1'b0;
        chk("route_out1", 32'(out1), 32'h1111);
        chk("route_out2", 32'(out2), 32'h2222);
        chk("route_out3", 32'(out3), 32'h3333);
        chk("route_out4", 32'(out4), 32'h4444);
        chk("route_valid", 32'(out_valid), 32'hF);
        chk("route_count", 32'(xfer_count), 32'd4);

        // Back-pressure on slot 1
        in_data = 16'hBEEF; op = 2'd0; in_valid = 1'b1;
        #1 chk("bp_stall_ready", 32'(in_ready), 32'h0);
        op = 2'd1;
        #1 chk("bp_other_full", 32'(in_ready), 32'h0);
        op = 2'd0;
        @(negedge clock);
        chk("bp_hold_out1", 32'(out1), 32'h1111);
        chk("bp_hold_count", 32'(xfer_count), 32'd4);
        out_ready = 4'b0001;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
        @(negedge clock) begin in_valid = 1'b0; out_ready = 4'b0000; end
        chk("bp_out1", 32'(out1), 32'hBEEF);
        chk("bp_valid", 32'(out_valid), 32'hF);
        chk("bp_count", 32'(xfer_count), 32'd5);

        // Streaming into slot 3 with its consumer always ready
        out_ready = 4'b0100; op = 2'd2; in_valid = 1'b1;
        n_hs = 0;
        for (int w = 1; w <= 16; w++) begin
            in_data = 16'(w);
            #1 chk($sformatf("stream_ready_%0d", w), 32'(in_ready), 32'h1);
            @(negedge clock);
            chk($sformatf("stream_out3_%0d", w), 32'(out3), 32'(w));
        end
        chk("stream_handshakes", 32'(n_hs), 32'd16);
        chk("stream_valid", 32'(out_valid), 32'hF);
        chk("stream_count", 32'(xfer_count), 32'd21);
        in_valid = 1'b0; out_ready = 4'b0000;

        // Counter wrap: stream into slot 4 until 0xFFFF, then one more
        @(negedge clock) begin out_ready = 4'b1000; op = 2'd3; in_data = 16'h5A5A; in_valid = 1'b1; end
        repeat (16'hFFFF - 21) @(negedge clock);
        in_valid = 1'b0;
        chk("wrap_pre", 32'(xfer_count), 32'hFFFF);
        in_valid = 1'b1; in_data = 16'h7777;
        @(negedge clock) begin in_valid = 1'b0; out_ready = 4'b0000; end
        chk("wrap_zero", 32'(xfer_count), 32'h0);
        chk("wrap_out4", 32'(out4), 32'h7777);

        // Drain slots 1 and 3, leaving 4'b1010, then reset between edges
        out_ready = 4'b0101;
        @(negedge clock) out_ready = 4'b0000;
        chk("pre_reset_valid", 32'(out_valid), 32'hA);
        in_valid = 1'b1; op = 2'd1; in_data = 16'hDEAD;
        #2 reset = 1'b1;
        #1 chk_cleared("async_reset");
        @(negedge clock);
        chk("reset_no_count", 32'(xfer_count), 32'h0);
        chk("reset_no_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1 chk("post_reset_ready", 32'(in_ready), 32'h1);

        // Transfer after reset release
        in_valid = 1'b1; op = 2'd1; in_data = 16'hA5A5;
        @(negedge clock) in_valid = 1'b0;
        chk("post_reset_out2", 32'(out2), 32'hA5A5);
        chk("post_reset_valid", 32'(out_valid), 32'h2);
        chk("post_reset_count", 32'(xfer_count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/four_way_demux_component.md
# four_way_demux_component

Registered 1-to-4 demultiplexer, the distribution counterpart to the four-way select mux in the processor datapath. A single 16-bit producer stream is steered by a 2-bit `op` into one of four independent output slots. Each slot holds one word and has its own valid/ready handshake, so a stalled consumer blocks only its own slot. A wrapping transfer counter supports debug and verification.

## Interface
Parameters:
- `WIDTH`, default 16: data width of the input and of each output slot.

Ports:
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `in_data`  in  WIDTH  — word to distribute.
- `in_valid`  in  1  — producer has a word on `in_data`.
- `in_ready`  out  1  — block accepts the word this cycle (combinational).
- `op`  in  2  — destination select: 00→out1, 01→out2, 10→out3, 11→out4. Sampled with `in_valid`.
- `out1`, `out2`, `out3`, `out4`  out  WIDTH each  — registered slot data.
- `out_valid`  out  4  — bit i set means slot i+1 holds an undelivered word.
- `out_ready`  in  4  — bit i set means consumer i+1 takes slot i+1 this cycle.
- `xfer_count`  out  16  — count of accepted input words, wrapping.

## Operation
- Slot i is the register pair `out(i+1)` and `out_valid[i]`.
- Input transfer occurs when `in_valid && in_ready`.
- `in_ready = !out_valid[op] || out_ready[op]`. It depends only on the selected slot, so other slots' state never stalls the input.
- Output transfer occurs on slot i when `out_valid[i] && out_ready[i]`.
- Per slot, per cycle:
  - input transfer targets slot i: data ← `in_data`, `out_valid[i]` ← 1. This applies whether or not slot i drains the same cycle, so refill on drain is allowed.
  - slot i drains with no refill: `out_valid[i]` ← 0; data register holds its last value.
  - otherwise: slot i holds.
- Only the slot selected by `op` can be written in a given cycle. Other slots drain independently and in parallel.
- `out_ready[i]` is ignored while `out_valid[i]` = 0.
- `xfer_count` increments by 1 on each input transfer and wraps from 0xFFFF to 0x0000.
- `op` and `in_data` are don't-care when `in_valid` = 0.

## Timing
- Reset values (asynchronous): `out1`..`out4` = 0, `out_valid` = 4'b0000, `xfer_count` = 0. Consequently `in_ready` = 1 while and after reset.
- Latency: a word accepted on edge N is visible on its slot, with its valid bit set, immediately after edge N (1 cycle).
- Throughput: one word per cycle into any slot whose consumer holds `out_ready` high. Back-to-back words to the same slot are sustained.
- Full slot with `out_ready` low: `in_ready` = 0 for that `op`. The producer must hold `in_data` and `op` stable until accepted.
- Switching `op` to an empty slot while another slot is full: accepted the same cycle.
- Combinational path `out_ready`/`op` → `in_ready` is intended. There is no path from `in_valid` to `in_ready`.
- Reset asserted mid-operation: pending words are discarded at once and the counter clears. No transfer is counted on the edge where reset is active.

## Test plan
- Reset, then check every output: `out1`..`out4` = 0, `out_valid` = 0, `in_ready` = 1, `xfer_count` = 0.
- Basic routing with `out_ready` = 4'b0000:
  - send 0x1111/op 00, 0x2222/op 01, 0x3333/op 10, 0x4444/op 11 on consecutive cycles;
  - expect `out1`..`out4` = 0x1111..0x4444, `out_valid` = 4'b1111, `xfer_count` = 4.
- Back-pressure:
  - with slot 1 full and `out_ready[0]` = 0, drive 0xBEEF/op 00: expect `in_ready` = 0 and `out1` unchanged at 0x1111;
  - raise `out_ready[0]`: expect acceptance that cycle, then `out1` = 0xBEEF with `out_valid[0]` = 1.
- Streaming into one slot:
  - `out_ready` = 4'b0100, stream 0x0001..0x0010 with op 10;
  - expect `in_ready` held at 1, `out3` showing each word one cycle after acceptance, 16 consumer handshakes, and `xfer_count` advanced by 16.
- Counter wrap: preload 0xFFFF transfers (or force the counter), then one more transfer; expect `xfer_count` = 0x0000.
- Reset mid-stream:
  - assert `reset` between edges while `out_valid` = 4'b1010;
  - expect all outputs to clear asynchronously, before the next edge, and `in_ready` = 1 after release.
